sram_req_ctrl: RTL and testbench
================================

Name: sram_req_ctrl

Overview:
- Request-side controller directly upstream of the single-port SRAM core; sole driver of its addr/data_in/write_en/read_en pins, sole consumer of its data_out.
- Converts a valid/ready request channel into one-cycle SRAM strobes, absorbs the core's 1-cycle read latency, returns read data on a valid/ready response channel with backpressure.
- Optional post-reset clear sweep zeroes the whole array before traffic is accepted.

Parameters:
ADDR_WIDTH, 8, SRAM address width; array depth = 2**ADDR_WIDTH.
DATA_WIDTH, 32, SRAM word width.
RSP_DEPTH, 4, response FIFO entries; power of two, >=2; >=3 required for one-read-per-cycle throughput.
CLEAR_ON_RESET, 1, 1 = run zero-fill sweep after reset; 0 = enter RUN directly.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  reset; asynchronous, active-low.
req_valid  input  1  request present.
req_ready  output  1  controller accepts request this cycle.
req_write  input  1  1 = write, 0 = read.
req_addr  input  ADDR_WIDTH  request address.
req_wdata  input  DATA_WIDTH  write data.
rsp_valid  output  1  read data available.
rsp_ready  input  1  consumer accepts response.
rsp_rdata  output  DATA_WIDTH  read data, in request order.
busy  output  1  clear sweep in progress.
mem_addr  output  ADDR_WIDTH  to SRAM addr.
mem_data_in  output  DATA_WIDTH  to SRAM data_in.
mem_write_en  output  1  to SRAM write_en.
mem_read_en  output  1  to SRAM read_en.
mem_data_out  input  DATA_WIDTH  from SRAM data_out.

Behaviour:
- Reset (async, rst_n=0): state = INIT if CLEAR_ON_RESET else RUN; clear counter 0; FIFO empty; inflight 0. Outputs during/after reset: req_ready 0 (in INIT), rsp_valid 0, rsp_rdata 0, busy = CLEAR_ON_RESET, mem_write_en 0, mem_read_en 0. Reset mid-operation discards in-flight reads and queued responses; no response ever emitted for them.
- INIT: each cycle mem_write_en=1, mem_addr=clear counter, mem_data_in=0; counter increments. After writing address 2**ADDR_WIDTH-1 -> RUN next cycle. Exactly 2**ADDR_WIDTH cycles with busy=1; req_ready=0 throughout.
- RUN: busy=0. Accept (fire) = req_valid & req_ready; at most one request per cycle.
- req_ready in RUN = write ? 1 : (fifo_count + inflight < RSP_DEPTH). Depends only on req_write and registered state, never on req_valid.
- mem_* driven combinationally in the fire cycle: mem_addr=req_addr, mem_data_in=req_wdata, mem_write_en=fire&req_write, mem_read_en=fire&~req_write. Non-fire cycles: both strobes 0, mem_addr/mem_data_in hold last driven value. Never both strobes high.
- Read pipeline: fire in cycle N sets inflight; in cycle N+1 mem_data_out is pushed into FIFO at cycle end; rsp_valid earliest in cycle N+2 (latency 2 from acceptance).
- FIFO: pop on rsp_valid & rsp_ready; push and pop in same cycle keep count unchanged. rsp_rdata = head entry; holds stable while rsp_valid & ~rsp_ready. Credit check guarantees push never hits full.
- Ordering: responses strictly in read-request order. Write at cycle N then read same address at N+1 returns the new data.
- Throughput with RSP_DEPTH>=3 and rsp_ready=1: one read accepted per cycle indefinitely.
- Widths: clear counter ADDR_WIDTH+1 bits (terminal detect on MSB); fifo_count clog2(RSP_DEPTH)+1 bits; FIFO pointers wrap modulo RSP_DEPTH.

Test Plan:
- Reset, CLEAR_ON_RESET=1, ADDR_WIDTH=4 -> busy=1 for 16 cycles, mem_write_en=1 with addresses 0..15 and data 0, req_ready=0; then busy=0; read addr 7 returns 0x00000000.
- Write 0xDEADBEEF @0x12, next cycle read 0x12 -> rsp_valid exactly 2 cycles after read fire, rsp_rdata=0xDEADBEEF.
- Back-to-back reads @1,2,3,4 (preloaded 0x11,0x22,0x33,0x44), rsp_ready=1, RSP_DEPTH=4 -> req_ready never drops, responses 0x11,0x22,0x33,0x44 on consecutive cycles.
- rsp_ready=0, issue 6 reads, RSP_DEPTH=4 -> exactly 4 accepted then req_ready=0 for reads while writes still accepted; rsp_rdata stable; release rsp_ready -> 4 responses in order, remaining 2 reads then accepted.
- Assert rst_n low with 2 reads queued and 1 in flight -> rsp_valid=0 immediately, clear sweep restarts, no stale response after sweep.
- Random mix of reads/writes with random rsp_ready, checked against a reference memory model -> all responses match, mem_write_en & mem_read_en never both 1.

Source files
------------

// File: rtl/sram_req_ctrl.sv
// sram_req_ctrl
// Request-side controller placed directly in front of a single-port SRAM core.
// It owns every SRAM input pin and is the only consumer of the SRAM read data.
//
// Function:
//   - Turns a valid/ready request channel into one-cycle SRAM write/read strobes.
//   - Absorbs the core's one-cycle read latency and returns read data, in request
//     order, on a valid/ready response channel that may apply backpressure.
//   - Optionally zero-fills the whole array after reset before accepting traffic.
//
// Ports:
//   clk           in   clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   req_valid     in   request present
//   req_ready     out  request accepted this cycle (independent of req_valid)
//   req_write     in   1 = write, 0 = read
//   req_addr      in   [ADDR_WIDTH] request address
//   req_wdata     in   [DATA_WIDTH] write data
//   rsp_valid     out  read data available at rsp_rdata
//   rsp_ready     in   consumer accepts the response
//   rsp_rdata     out  [DATA_WIDTH] read data (zero when rsp_valid is low)
//   busy          out  post-reset clear sweep in progress
//   mem_addr      out  [ADDR_WIDTH] SRAM address
//   mem_data_in   out  [DATA_WIDTH] SRAM write data
//   mem_write_en  out  SRAM write strobe
//   mem_read_en   out  SRAM read strobe
//   mem_data_out  in   [DATA_WIDTH] SRAM read data, valid one cycle after read_en
module sram_req_ctrl #(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned RSP_DEPTH      = 4,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_write_en,
  output logic                  mem_read_en,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  localparam int unsigned PTR_W = $clog2(RSP_DEPTH);
  // Occupancy = queued entries + one possible in-flight read; needs one extra bit
  // over the FIFO count so that RSP_DEPTH + 1 cannot wrap.
  localparam int unsigned OCC_W = PTR_W + 2;

  localparam logic [ADDR_WIDTH:0] CLR_ONE   = (ADDR_WIDTH + 1)'(1);
  localparam logic [PTR_W-1:0]    PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]      CNT_ONE   = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]      CNT_FULL  = (PTR_W + 1)'(RSP_DEPTH);
  localparam logic [OCC_W-1:0]    DEPTH_OCC = OCC_W'(RSP_DEPTH);

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam state_t RST_STATE = CLEAR_ON_RESET ? S_INIT : S_RUN;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                  state_q, state_d;
  logic [ADDR_WIDTH:0]     clr_cnt_q, clr_cnt_d;
  logic                    inflight_q, inflight_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]          cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic [DATA_WIDTH-1:0]   mem_wdata_q;
  logic [DATA_WIDTH-1:0]   fifo_mem [RSP_DEPTH];

  logic                    run;
  logic [OCC_W-1:0]        occ;
  logic                    credit_ok;
  logic                    fire;
  logic                    wr_fire;
  logic                    rd_fire;
  logic                    sweep_we;
  logic                    push;
  logic                    pop;

  // ---------------------------------------------------------------------------
  // Request acceptance
  // ---------------------------------------------------------------------------
  assign run       = (state_q == S_RUN);
  assign occ       = {1'b0, cnt_q} + {{(PTR_W + 1){1'b0}}, inflight_q};
  assign credit_ok = (occ < DEPTH_OCC);

  // Writes never produce a response, so only reads consume credit. The ready
  // decision looks at req_write and registered state only, never at req_valid.
  assign req_ready = run & (req_write | credit_ok);
  assign fire      = req_valid & req_ready;
  assign wr_fire   = fire & req_write;
  assign rd_fire   = fire & ~req_write;

  assign busy      = (state_q == S_INIT);

  // ---------------------------------------------------------------------------
  // SRAM pin drive
  // ---------------------------------------------------------------------------
  // The sweep strobe is qualified with rst_n so the core sees no write while
  // reset is held; the first sweep write happens in the first cycle after release.
  assign sweep_we     = busy & rst_n;
  assign mem_write_en = sweep_we | wr_fire;
  assign mem_read_en  = rd_fire;

  // Address/data hold their last driven value in idle cycles so the core pins
  // do not toggle without a strobe.
  always_comb begin
    mem_addr    = mem_addr_q;
    mem_data_in = mem_wdata_q;
    if (busy) begin
      mem_addr    = clr_cnt_q[ADDR_WIDTH-1:0];
      mem_data_in = '0;
    end else if (fire) begin
      mem_addr    = req_addr;
      mem_data_in = req_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Control next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      S_INIT: begin
        clr_cnt_d = clr_cnt_q + CLR_ONE;
        // Counter MSB sets once the last address has been written this cycle.
        if (clr_cnt_d[ADDR_WIDTH]) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        state_d = S_RUN;
      end
      default: begin
        state_d = RST_STATE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read return path: one cycle of SRAM latency, then the response FIFO
  // ---------------------------------------------------------------------------
  assign inflight_d = rd_fire;
  assign push       = inflight_q;
  assign rsp_valid  = (cnt_q != '0);
  assign pop        = rsp_valid & rsp_ready;

  assign wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
  assign rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // Head entry; forced to zero when empty so stale data never shows.
  assign rsp_rdata = rsp_valid ? fifo_mem[rd_ptr_q] : '0;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RST_STATE;
      clr_cnt_q  <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  // Data-only storage; meaningless until qualified by the control state above.
  always_ff @(posedge clk) begin
    mem_addr_q  <= mem_addr;
    mem_wdata_q <= mem_data_in;
    if (push) begin
      fifo_mem[wr_ptr_q] <= mem_data_out;
    end
  end

`ifndef SYNTHESIS
  a_one_strobe: assert property (@(posedge clk) disable iff (!rst_n)
    !(mem_write_en && mem_read_en));
  // Credit accounting must make a push into a full FIFO impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(inflight_q && (cnt_q == CNT_FULL)));
`endif

endmodule

// File: tb/tb_sram_req_ctrl.sv
module tb_sram_req_ctrl;

  localparam int AW        = 5;
  localparam int DW        = 32;
  localparam int RSP_DEPTH = 4;
  localparam int DEPTH     = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_in;
  logic          mem_write_en;
  logic          mem_read_en;
  logic [DW-1:0] mem_data_out = '0;

  always #5 clk = ~clk;

  sram_req_ctrl #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .RSP_DEPTH     (RSP_DEPTH),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .busy        (busy),
    .mem_addr    (mem_addr),
    .mem_data_in (mem_data_in),
    .mem_write_en(mem_write_en),
    .mem_read_en (mem_read_en),
    .mem_data_out(mem_data_out)
  );

  // Behavioural single-port SRAM core with one-cycle read latency.
  logic [DW-1:0] sram [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) sram[i] = $urandom | 32'h1;
  end
  always @(posedge clk) begin
    if (mem_write_en) sram[mem_addr] <= mem_data_in;
    if (mem_read_en)  mem_data_out   <= sram[mem_addr];
  end

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] sb [$];
  logic [DW-1:0] ref_mem [DEPTH];
  logic          stall_prev = 1'b0;
  logic [DW-1:0] rdata_prev = '0;
  logic          m_fire;
  logic          m_exp_rdy;
  logic [DW-1:0] m_exp;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Scoreboard / protocol monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", rsp_valid, 1);
        check("hold_rdata", rsp_rdata, rdata_prev);
      end
      check("one_strobe", mem_write_en & mem_read_en, 0);
      if (!busy) begin
        m_fire    = req_valid & req_ready;
        m_exp_rdy = req_write || (sb.size() < RSP_DEPTH);
        check("req_ready_model", req_ready, m_exp_rdy);
        check("mem_we", mem_write_en, m_fire & req_write);
        check("mem_re", mem_read_en, m_fire & ~req_write);
        if (m_fire) begin
          check("mem_addr", mem_addr, req_addr);
          if (req_write) check("mem_data_in", mem_data_in, req_wdata);
        end
        if (rsp_valid && rsp_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected actual=0x%0h required=none at %0t", rsp_rdata, $time);
          end else begin
            m_exp = sb.pop_front();
            check("rsp_rdata", rsp_rdata, m_exp);
          end
        end
        if (m_fire) begin
          if (req_write) ref_mem[req_addr] = req_wdata;
          else           sb.push_back(ref_mem[req_addr]);
        end
      end
      stall_prev = rsp_valid && !rsp_ready;
      rdata_prev = rsp_rdata;
    end
  end

  // Called at posedge+1 right after reset release.
  task automatic sweep_check();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      check("sweep_busy", busy, 1);
      check("sweep_we", mem_write_en, 1);
      check("sweep_re", mem_read_en, 0);
      check("sweep_addr", mem_addr, i);
      check("sweep_data", mem_data_in, 0);
      check("sweep_ready", req_ready, 0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("sweep_done_busy", busy, 0);
    check("sweep_done_we", mem_write_en, 0);
    @(posedge clk); #1;
  endtask

  task automatic do_req(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic done = 1'b0;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      if (req_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    check("req_accept", done, 1);
  endtask

  task automatic wait_drain();
    logic done = 1'b0;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && !rsp_valid) done = 1'b1;
      @(posedge clk); #1;
    end
    check("drain_done", done, 1);
    check("drain_empty", sb.size(), 0);
  endtask

  typedef struct packed {
    logic          vld;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          e_rdy;
    logic          e_we;
    logic          e_re;
    logic          e_rv;
    logic [DW-1:0] e_rd;
  } vec_t;

  function automatic vec_t mk(input logic vld, input logic wr, input int a,
                              input logic [DW-1:0] wd, input logic erdy, input logic ewe,
                              input logic ere, input logic erv, input logic [DW-1:0] erd);
    vec_t v;
    v.vld = vld; v.wr = wr; v.addr = a[AW-1:0]; v.wdata = wd;
    v.e_rdy = erdy; v.e_we = ewe; v.e_re = ere; v.e_rv = erv; v.e_rd = erd;
    return v;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [11];
    int   acc;

    // Preload 1..4, then back-to-back reads with rsp_ready high.
    tbl[0]  = mk(1, 1, 1, 32'h11, 1, 1, 0, 0, 32'h0);
    tbl[1]  = mk(1, 1, 2, 32'h22, 1, 1, 0, 0, 32'h0);
    tbl[2]  = mk(1, 1, 3, 32'h33, 1, 1, 0, 0, 32'h0);
    tbl[3]  = mk(1, 1, 4, 32'h44, 1, 1, 0, 0, 32'h0);
    tbl[4]  = mk(1, 0, 1, 32'h0,  1, 0, 1, 0, 32'h0);
    tbl[5]  = mk(1, 0, 2, 32'h0,  1, 0, 1, 0, 32'h0);
    tbl[6]  = mk(1, 0, 3, 32'h0,  1, 0, 1, 1, 32'h11);
    tbl[7]  = mk(1, 0, 4, 32'h0,  1, 0, 1, 1, 32'h22);
    tbl[8]  = mk(0, 0, 0, 32'h0,  1, 0, 0, 1, 32'h33);
    tbl[9]  = mk(0, 0, 0, 32'h0,  1, 0, 0, 1, 32'h44);
    tbl[10] = mk(0, 0, 0, 32'h0,  1, 0, 0, 0, 32'h0);

    // Reset state
    @(negedge clk);
    check("rst_busy", busy, 1);
    check("rst_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_we", mem_write_en, 0);
    check("rst_re", mem_read_en, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    sweep_check();

    // Cleared array reads back zero
    rsp_ready = 1'b1;
    do_req(1'b0, 5'd7, '0);
    wait_drain();

    // Write then read-after-write with 2-cycle response latency
    req_valid = 1'b1; req_write = 1'b1; req_addr = 5'h12; req_wdata = 32'hDEADBEEF;
    @(negedge clk);
    check("lat_wr_ready", req_ready, 1);
    check("lat_wr_we", mem_write_en, 1);
    @(posedge clk); #1;
    req_write = 1'b0;
    @(negedge clk);
    check("lat_rd_fire", req_ready & mem_read_en, 1);
    check("lat_valid_n0", rsp_valid, 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("lat_valid_n1", rsp_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("lat_valid_n2", rsp_valid, 1);
    check("lat_rdata", rsp_rdata, 32'hDEADBEEF);
    @(posedge clk); #1;
    @(negedge clk);
    check("lat_valid_n3", rsp_valid, 0);
    @(posedge clk); #1;

    // Table-driven back-to-back traffic
    rsp_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      req_valid = tbl[i].vld; req_write = tbl[i].wr;
      req_addr = tbl[i].addr; req_wdata = tbl[i].wdata;
      @(negedge clk);
      check("tbl_ready", req_ready, tbl[i].e_rdy);
      check("tbl_we", mem_write_en, tbl[i].e_we);
      check("tbl_re", mem_read_en, tbl[i].e_re);
      check("tbl_rsp_valid", rsp_valid, tbl[i].e_rv);
      if (tbl[i].e_rv) check("tbl_rsp_rdata", rsp_rdata, tbl[i].e_rd);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    wait_drain();

    // Backpressure: six reads with rsp_ready low
    do_req(1'b1, 5'd5, 32'h55);
    do_req(1'b1, 5'd6, 32'h66);
    rsp_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      req_valid = 1'b1; req_write = 1'b0; req_addr = AW'(1 + acc);
      @(negedge clk);
      if (req_ready) acc++;
      @(posedge clk); #1;
    end
    check("bp_accepted", acc, 4);
    req_write = 1'b0; req_addr = 5'd5;
    @(negedge clk);
    check("bp_read_blocked", req_ready, 0);
    check("bp_rsp_valid", rsp_valid, 1);
    check("bp_head", rsp_rdata, 32'h11);
    @(posedge clk); #1;
    req_write = 1'b1; req_addr = 5'h1F; req_wdata = 32'hA5A5A5A5;
    @(negedge clk);
    check("bp_write_ok", req_ready, 1);
    @(posedge clk); #1;
    req_write = 1'b0; req_addr = AW'(1 + acc);
    rsp_ready = 1'b1;
    for (int c = 0; c < 20 && acc < 6; c++) begin
      @(negedge clk);
      if (req_ready) acc++;
      @(posedge clk); #1;
      req_addr = AW'(1 + acc);
    end
    req_valid = 1'b0;
    check("bp_all_accepted", acc, 6);
    wait_drain();

    // Reset with two responses queued and one read in flight
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req_valid = 1'b1; req_write = 1'b0; req_addr = AW'(k + 1);
      @(negedge clk);
      check("mr_ready", req_ready, 1);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    check("mr_queued", rsp_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mr_rst_valid", rsp_valid, 0);
    check("mr_rst_rdata", rsp_rdata, 0);
    check("mr_rst_busy", busy, 1);
    check("mr_rst_ready", req_ready, 0);
    check("mr_rst_we", mem_write_en, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sweep_check();
    rsp_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("mr_no_stale", rsp_valid, 0);
      @(posedge clk); #1;
    end

    // Random mix against the reference memory
    for (int c = 0; c < 400; c++) begin
      req_valid = ($urandom_range(0, 2) != 0);
      req_write = 1'($urandom_range(0, 1));
      req_addr  = AW'($urandom_range(0, 7));
      req_wdata = $urandom;
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
